// File: rtl/riscv_pkg.sv
// Shared RISC-V architectural constants used by the writeback scheduler and its arbiter.
package riscv_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  // x0 is hardwired to zero, so it is never written and never tracked as busy.
  function automatic logic is_arch_rd(input logic [REG_ADDR_W-1:0] a);
    return a != X0;
  endfunction
endpackage

// File: rtl/regfile_wb_sched_if.sv
// Writeback request bus from the execute/memory units to the register-file write scheduler.
interface regfile_wb_sched_if #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
);
  logic [N_REQ-1:0]                         wb_valid;
  logic [N_REQ-1:0]                         wb_ready;
  logic [N_REQ*riscv_pkg::REG_ADDR_W-1:0]   wb_rd;
  logic [N_REQ*XLEN-1:0]                    wb_data;

  modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_vld
);
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    grant = grant_vld ? (N'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: round-robin writeback arbitration plus a busy
// scoreboard that flags read-after-write hazards for decode.
module regfile_wb_sched #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32,
  parameter int NREG  = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  regfile_wb_sched_if.slave                  wb,
  input  logic                               rsv_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]   rsv_rd,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]   rs1_addr,
  input  logic [riscv_pkg::REG_ADDR_W-1:0]   rs2_addr,
  output logic                               hazard,
  output logic                               reg_wr_en,
  output logic [riscv_pkg::REG_ADDR_W-1:0]   rd_addr,
  output logic [XLEN-1:0]                    w_data,
  output logic [NREG-1:0]                    busy_vec
);
  import riscv_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]           ptr;
  logic [NREG-1:0]         busy;
  logic [NREG-1:0]         busy_nxt;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        gnt;
  logic [PW-1:0]           gnt_idx;
  logic                    gnt_vld;
  logic [REG_ADDR_W-1:0]   sel_rd;
  logic [XLEN-1:0]         sel_data;
  logic                    wr_go;
  logic                    vld_p1;
  logic [REG_ADDR_W-1:0]   rd_p1;
  logic [XLEN-1:0]         data_p1;

  // Stage p0: arbitration and scoreboard lookup (combinational)
  assign req = rst ? '0 : wb.wb_valid;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  assign wb.wb_ready = gnt;
  assign sel_rd      = wb.wb_rd[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_data    = wb.wb_data[int'(gnt_idx)*XLEN +: XLEN];
  assign wr_go       = gnt_vld && is_arch_rd(sel_rd);

  assign hazard = (is_arch_rd(rs1_addr) && busy[rs1_addr])
               || (is_arch_rd(rs2_addr) && busy[rs2_addr]);

  // Clear is applied before set so a same-cycle reservation of the same rd survives.
  always_comb begin
    busy_nxt = busy;
    if (wr_go)
      busy_nxt[sel_rd] = 1'b0;
    if (rsv_valid && is_arch_rd(rsv_rd))
      busy_nxt[rsv_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Stage p1: registered regfile write port, pointer and scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      busy    <= '0;
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      if (gnt_vld)
        ptr <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
      busy   <= busy_nxt;
      vld_p1 <= wr_go;
      if (wr_go) begin
        rd_p1   <= sel_rd;
        data_p1 <= sel_data;
      end
    end
  end

  assign reg_wr_en = vld_p1;
  assign rd_addr   = rd_p1;
  assign w_data    = data_p1;
  assign busy_vec  = busy;
endmodule
